// File: rtl/sigmul_iter_if.sv
// Operand/product handshake bundle for the iterative significand multiplier.
// The producer/consumer side uses master; sigmul_iter uses slave.
interface sigmul_iter_if #(
    parameter int NSIG = 10
);
    logic                in_valid;
    logic                in_ready;
    logic [NSIG:0]       a;
    logic [NSIG:0]       b;
    logic                out_valid;
    logic                out_ready;
    logic [2*NSIG+1:0]   p;
    logic                busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/sigmul_iter.sv
// Sequential shift-add significand multiplier: retires BPC multiplier bits per cycle
// and presents the exact (NSIG+1)x(NSIG+1) product behind a valid/ready handshake.
module sigmul_iter #(
    parameter int NSIG = 10,
    parameter int BPC  = 1
) (
    input  logic          clk,
    input  logic          rst,
    sigmul_iter_if.slave  bus
);
    localparam int N    = NSIG + 1;
    localparam int NCYC = (N + BPC - 1) / BPC;
    localparam int NPAD = NCYC * BPC;
    localparam int CW   = $clog2(NCYC + 1);
    localparam int PW   = 2 * N;

    generate
        if (BPC < 1 || BPC > N) begin : g_bad_bpc
            $error("sigmul_iter: BPC must lie in 1..NSIG+1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic                in_ready;
    logic                out_valid;
    logic                busy;
    logic                accept;
    logic                last;

    logic [N-1:0]        a_q;
    logic [NPAD-1:0]     b_q;
    logic [N-1:0]        hi;
    logic [NPAD-1:0]     lo;
    logic [CW-1:0]       cnt;
    logic [N+BPC-1:0]    sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        last       = (cnt == CW'(NCYC - 1));
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    state_next = bus.in_valid ? BUSY : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = bus.in_valid & in_ready;

    // One partial product per cycle; hi + a*chunk always fits in N+BPC bits.
    assign sum = {{BPC{1'b0}}, hi}
               + ({{BPC{1'b0}}, a_q} * {{N{1'b0}}, b_q[BPC-1:0]});

    always_ff @(posedge clk) begin
        if (rst) begin
            hi  <= '0;
            lo  <= '0;
            cnt <= '0;
        end else if (accept) begin
            a_q <= bus.a;
            b_q <= NPAD'(bus.b);
            hi  <= '0;
            lo  <= '0;
            cnt <= '0;
        end else if (busy) begin
            hi  <= sum[N+BPC-1:BPC];
            lo  <= (lo >> BPC) | (NPAD'(sum[BPC-1:0]) << (NPAD - BPC));
            b_q <= b_q >> BPC;
            cnt <= cnt + CW'(1);
        end
    end

    // After NCYC shifts {hi, lo} is the full product; padding bits above PW are zero.
    assign bus.p         = PW'({hi, lo});
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_sigmul_iter.sv
// Directed and randomized checks of sigmul_iter across several BPC settings
// (instances 0..5 use BPC = 1, 4, 2, 3, 5, 11 with NSIG = 10).
module tb_sigmul_iter;
    localparam int NI = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv   [NI];
    logic [10:0] av   [NI];
    logic [10:0] bv   [NI];
    logic        ordy [NI];
    wire         irdy [NI];
    wire         ov   [NI];
    wire         bsy  [NI];
    wire  [21:0] pw   [NI];

    int checks = 0;
    int errors = 0;

    function automatic int bpc_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            2:       return 2;
            3:       return 3;
            4:       return 5;
            default: return 11;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            sigmul_iter_if #(.NSIG(10)) bus ();
            assign bus.in_valid  = iv[gi];
            assign bus.a         = av[gi];
            assign bus.b         = bv[gi];
            assign bus.out_ready = ordy[gi];
            assign irdy[gi]      = bus.in_ready;
            assign ov[gi]        = bus.out_valid;
            assign bsy[gi]       = bus.busy;
            assign pw[gi]        = bus.p;
            sigmul_iter #(.NSIG(10), .BPC(bpc_of(gi))) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand pair on an idle instance and wait for its product.
    task automatic do_mul(input int idx, input logic [10:0] x, input logic [10:0] y,
                          output int lat, output logic [21:0] prod, output bit bad);
        int w;
        bad  = 1'b0;
        lat  = -1;
        prod = '0;
        av[idx] = x;
        bv[idx] = y;
        iv[idx] = 1'b1;
        ordy[idx] = 1'b0;
        #1;
        w = 0;
        while (!irdy[idx] && w < 50) begin
            tick();
            w++;
        end
        if (irdy[idx]) begin
            tick();
            iv[idx] = 1'b0;
            lat = 0;
            while (!ov[idx] && lat < 100) begin
                if (!bsy[idx] || irdy[idx]) bad = 1'b1;
                tick();
                lat++;
            end
            prod = pw[idx];
        end else begin
            iv[idx] = 1'b0;
        end
    endtask

    task automatic drain(input int idx);
        iv[idx]   = 1'b0;
        ordy[idx] = 1'b1;
        tick();
        ordy[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; av[i] = '0; bv[i] = '0; ordy[i] = 1'b0;
        end
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || bsy[i] !== 1'b0 || irdy[i] !== 1'b1 || pw[i] !== 22'h0) begin
                errors++;
                $display("FAIL reset[%0d]: out_valid=%b busy=%b in_ready=%b p=%h, required 0 0 1 000000",
                         i, ov[i], bsy[i], irdy[i], pw[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_unity();
        int lat; logic [21:0] pr; bit bad;
        do_mul(0, 11'h400, 11'h400, lat, pr, bad);
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL unity_latency: got %0d, required 11", lat); end
        checks++;
        if (pr !== 22'h100000) begin errors++; $display("FAIL unity_p: got %h, required 100000", pr); end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL unity_busy: busy/in_ready glitch seen while iterating"); end
        drain(0);
        checks++;
        if (irdy[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL unity_idle: in_ready=%b out_valid=%b, required 1 0", irdy[0], ov[0]);
        end
    endtask

    task automatic test_bpc4();
        int lat; logic [21:0] pr; bit bad;
        do_mul(1, 11'h7FF, 11'h7FF, lat, pr, bad);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL bpc4_latency: got %0d, required 3", lat); end
        checks++;
        if (pr !== 22'h3FF001) begin errors++; $display("FAIL bpc4_max: got %h, required 3ff001", pr); end
        drain(1);
        do_mul(1, 11'h600, 11'h600, lat, pr, bad);
        checks++;
        if (pr !== 22'h240000) begin errors++; $display("FAIL bpc4_msb: got %h, required 240000", pr); end
        drain(1);
    endtask

    task automatic test_backpressure();
        int lat; logic [21:0] pr; bit bad;
        do_mul(1, 11'h123, 11'h045, lat, pr, bad);
        checks++;
        if (pr !== 22'h004E6F) begin errors++; $display("FAIL bp_first: got %h, required 004e6f", pr); end
        for (int k = 0; k < 5; k++) begin
            av[1] = 11'($urandom);
            bv[1] = 11'($urandom);
            iv[1] = 1'($urandom);
            ordy[1] = 1'b0;
            tick();
            checks++;
            if (pw[1] !== 22'h004E6F || ov[1] !== 1'b1 || irdy[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: p=%h out_valid=%b in_ready=%b, required 004e6f 1 0",
                         k, pw[1], ov[1], irdy[1]);
            end
        end
        ordy[1] = 1'b1; iv[1] = 1'b1; av[1] = 11'h555; bv[1] = 11'h003;
        #1;
        checks++;
        if (irdy[1] !== 1'b1) begin errors++; $display("FAIL bp_ready_follow: in_ready=%b, required 1", irdy[1]); end
        tick();
        iv[1] = 1'b0; ordy[1] = 1'b0;
        checks++;
        if (bsy[1] !== 1'b1 || ov[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_b2b_accept: busy=%b out_valid=%b, required 1 0", bsy[1], ov[1]);
        end
        lat = 0;
        while (!ov[1] && lat < 100) begin tick(); lat++; end
        checks++;
        if (lat !== 3 || pw[1] !== 22'h000FFF) begin
            errors++;
            $display("FAIL bp_b2b_result: latency=%0d p=%h, required 3 000fff", lat, pw[1]);
        end
        drain(1);
    endtask

    task automatic test_reset_mid();
        int lat; logic [21:0] pr; bit bad;
        av[0] = 11'h3FF; bv[0] = 11'h3FF; iv[0] = 1'b1; ordy[0] = 1'b0;
        tick();
        iv[0] = 1'b0;
        repeat (5) tick();
        checks++;
        if (bsy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_busy: busy=%b, required 1", bsy[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ov[0] !== 1'b0 || bsy[0] !== 1'b0 || irdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle: out_valid=%b busy=%b in_ready=%b, required 0 0 1", ov[0], bsy[0], irdy[0]);
        end
        do_mul(0, 11'h401, 11'h401, lat, pr, bad);
        checks++;
        if (lat !== 11 || pr !== 22'h100801) begin
            errors++;
            $display("FAIL rstmid_fresh: latency=%0d p=%h, required 11 100801", lat, pr);
        end
        drain(0);
    endtask

    task automatic test_capture_zero();
        int lat; logic [21:0] pr; bit bad;
        av[2] = 11'h2AB; bv[2] = 11'h1CD; iv[2] = 1'b1; ordy[2] = 1'b0;
        tick();
        av[2] = 11'h7FF; bv[2] = 11'h7FF;
        lat = 0;
        while (!ov[2] && lat < 100) begin tick(); lat++; end
        iv[2] = 1'b0;
        checks++;
        if (lat !== 6 || pw[2] !== 22'h04CDEF) begin
            errors++;
            $display("FAIL capture: latency=%0d p=%h, required 6 04cdef", lat, pw[2]);
        end
        drain(2);
        do_mul(5, 11'h000, 11'h7FF, lat, pr, bad);
        checks++;
        if (lat !== 1 || pr !== 22'h0) begin errors++; $display("FAIL zero_bpc11: latency=%0d p=%h, required 1 000000", lat, pr); end
        drain(5);
        do_mul(4, 11'h7FF, 11'h000, lat, pr, bad);
        checks++;
        if (lat !== 3 || pr !== 22'h0) begin errors++; $display("FAIL zero_bpc5: latency=%0d p=%h, required 3 000000", lat, pr); end
        drain(4);
    endtask

    task automatic test_back_to_back();
        int sweep [5] = '{0, 2, 3, 4, 5};
        for (int s = 0; s < 5; s++) begin
            int idx;
            logic [21:0] q [$];
            int acc_n;
            int done_n;
            bit acc;
            bit dn;
            logic [21:0] snap;
            logic [21:0] expv;
            idx = sweep[s];
            acc_n = 0;
            done_n = 0;
            for (int c = 0; c < 600; c++) begin
                if (c < 400) begin
                    if (!iv[idx]) begin
                        iv[idx] = 1'($urandom_range(0, 1));
                        av[idx] = 11'($urandom);
                        bv[idx] = 11'($urandom);
                    end
                    ordy[idx] = ($urandom_range(0, 3) != 0);
                end else begin
                    iv[idx] = 1'b0;
                    ordy[idx] = 1'b1;
                end
                #1;
                acc  = iv[idx] && irdy[idx];
                dn   = ov[idx] && ordy[idx];
                snap = pw[idx];
                if (dn) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL sweep_dup bpc=%0d: unexpected product %h, required none", bpc_of(idx), snap);
                    end else begin
                        expv = q.pop_front();
                        if (snap !== expv) begin
                            errors++;
                            $display("FAIL sweep_p bpc=%0d: got %h, required %h", bpc_of(idx), snap, expv);
                        end
                    end
                    done_n++;
                end
                if (acc) begin
                    q.push_back(22'(av[idx]) * 22'(bv[idx]));
                    acc_n++;
                end
                tick();
                if (acc) iv[idx] = 1'b0;
            end
            ordy[idx] = 1'b0;
            checks++;
            if (q.size() != 0 || acc_n != done_n || acc_n < 5) begin
                errors++;
                $display("FAIL sweep_count bpc=%0d: accepted=%0d delivered=%0d pending=%0d, required equal and none pending",
                         bpc_of(idx), acc_n, done_n, q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_bpc4();
        test_backpressure();
        test_reset_mid();
        test_capture_zero();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
